// File: rtl/music_mixer_if.sv
// Bundles the mixer's codec-side and voice-side signals.
// master: drives frame/voice/control inputs (the bench or the system around the mixer).
// slave: the mixer itself; drives request, sample, beat and sticky status flags.
interface music_mixer_if #(
  parameter int NUM_VOICES = 3,
  parameter int SAMPLE_W   = 18
);
  logic                             new_frame;
  logic                             play;
  logic [NUM_VOICES-1:0]            voice_en;
  logic [NUM_VOICES*SAMPLE_W-1:0]   voice_sample;
  logic [NUM_VOICES-1:0]            voice_ready;
  logic [1:0]                       mix_shift;
  logic                             generate_next_sample;
  logic                             new_sample_generated;
  logic signed [SAMPLE_W-1:0]       sample_out;
  logic                             beat;
  logic                             overrun;
  logic                             voice_timeout;

  modport master (
    output new_frame, play, voice_en, voice_sample, voice_ready, mix_shift,
    input  generate_next_sample, new_sample_generated, sample_out, beat,
           overrun, voice_timeout
  );

  modport slave (
    input  new_frame, play, voice_en, voice_sample, voice_ready, mix_shift,
    output generate_next_sample, new_sample_generated, sample_out, beat,
           overrun, voice_timeout
  );
endinterface

// File: rtl/music_mixer.sv
// Voice mixer: on each codec frame edge, request samples from all voices, sum the enabled ones, attenuate, saturate.
// Latency: outputs are registered; request/sample update appear the cycle after the frame edge; a mix becomes visible at the next frame edge.
// Backpressure: none; late voices are cut off after TIMEOUT cycles and early frame edges are flagged as overrun.
// Ports: clk, reset (sync, active-low), bus (music_mixer_if.slave).
module music_mixer #(
  parameter int NUM_VOICES = 3,
  parameter int SAMPLE_W   = 18,
  parameter int BEAT_COUNT = 1000,
  parameter int TIMEOUT    = 64
) (
  input logic            clk,
  input logic            reset,
  music_mixer_if.slave   bus
);
  localparam int ACC_W = SAMPLE_W + 3;
  localparam int IDX_W = 3;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_VOICES - 1);
  localparam logic [9:0]       BC_LAST  = 10'(BEAT_COUNT - 1);
  localparam logic [7:0]       TO_LAST  = 8'(TIMEOUT - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {4'b0000, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {4'b1111, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, COLLECT, MIX, HOLD} state_t;
  state_t state, state_nxt;

  logic                        frame_q;
  logic [NUM_VOICES-1:0]       rdy, en_q;
  logic [1:0]                  shift_q;
  logic                        play_q;
  logic [7:0]                  tcnt;
  logic [IDX_W-1:0]            idx;
  logic [9:0]                  beat_cnt;
  logic signed [ACC_W-1:0]     acc;
  logic signed [SAMPLE_W-1:0]  hold [NUM_VOICES];
  logic signed [SAMPLE_W-1:0]  pending;

  logic                        frame_edge, req, ovr, timeout_hit;
  logic [NUM_VOICES-1:0]       rdy_next;
  logic signed [ACC_W-1:0]     term, sum_final, shifted;
  logic signed [SAMPLE_W-1:0]  sat;

  assign frame_edge = bus.new_frame & ~frame_q;
  assign req        = frame_edge & ((state == IDLE) | (state == HOLD));
  assign ovr        = frame_edge & ((state == COLLECT) | (state == MIX));
  // A ready arriving in the deadline cycle still counts toward completion.
  assign rdy_next   = rdy | bus.voice_ready;

  // One voice per MIX cycle; the final cycle's sum feeds shift and saturation directly.
  always_comb begin
    term = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (idx == IDX_W'(i) && en_q[i]) term = {{3{hold[i][SAMPLE_W-1]}}, hold[i]};
    end
    sum_final = acc + term;
    shifted   = sum_final >>> shift_q;
    if (shifted > SAT_MAX)      sat = SAT_MAX[SAMPLE_W-1:0];
    else if (shifted < SAT_MIN) sat = SAT_MIN[SAMPLE_W-1:0];
    else                        sat = shifted[SAMPLE_W-1:0];
  end

  always_comb begin
    state_nxt   = state;
    timeout_hit = 1'b0;
    case (state)
      IDLE, HOLD: if (frame_edge) state_nxt = COLLECT;
      COLLECT: begin
        if (&(rdy_next | ~en_q)) begin
          state_nxt = MIX;
        end else if (tcnt == TO_LAST) begin
          state_nxt   = MIX;
          timeout_hit = 1'b1;
        end
      end
      MIX: if (idx == IDX_LAST) state_nxt = HOLD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state                    <= IDLE;
      frame_q                  <= 1'b0;
      rdy                      <= '0;
      en_q                     <= '0;
      shift_q                  <= '0;
      play_q                   <= 1'b0;
      tcnt                     <= '0;
      idx                      <= '0;
      beat_cnt                 <= '0;
      acc                      <= '0;
      pending                  <= '0;
      for (int i = 0; i < NUM_VOICES; i++) hold[i] <= '0;
      bus.generate_next_sample <= 1'b0;
      bus.new_sample_generated <= 1'b0;
      bus.sample_out           <= '0;
      bus.beat                 <= 1'b0;
      bus.overrun              <= 1'b0;
      bus.voice_timeout        <= 1'b0;
    end else begin
      state                    <= state_nxt;
      frame_q                  <= bus.new_frame;
      bus.generate_next_sample <= req;
      bus.new_sample_generated <= 1'b0;
      bus.beat                 <= 1'b0;

      if (req) begin
        // Per-frame controls are frozen here so mid-frame changes cannot tear a mix.
        rdy     <= '0;
        tcnt    <= '0;
        idx     <= '0;
        acc     <= '0;
        en_q    <= bus.voice_en;
        shift_q <= bus.mix_shift;
        play_q  <= bus.play;
        if (beat_cnt == BC_LAST) begin
          bus.beat <= 1'b1;
          beat_cnt <= '0;
        end else begin
          beat_cnt <= beat_cnt + 10'd1;
        end
        if (state == HOLD) begin
          bus.sample_out           <= pending;
          bus.new_sample_generated <= 1'b1;
        end
      end

      if (ovr) bus.overrun <= 1'b1;

      if (state == COLLECT) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (bus.voice_ready[i]) hold[i] <= bus.voice_sample[i*SAMPLE_W +: SAMPLE_W];
        end
        rdy  <= rdy_next;
        tcnt <= tcnt + 8'd1;
        if (timeout_hit) bus.voice_timeout <= 1'b1;
      end

      if (state == MIX) begin
        acc <= sum_final;
        idx <= idx + 3'd1;
        if (idx == IDX_LAST) pending <= play_q ? sat : '0;
      end
    end
  end
endmodule

// File: doc/music_mixer.md
MUSIC_MIXER -- requirements
Module: music_mixer

Interface
REQ-001 Parameter NUM_VOICES, default 3: number of independent voice inputs, range 1..8.
REQ-002 Parameter SAMPLE_W, default 18: signed two's-complement sample width.
REQ-003 Parameter BEAT_COUNT, default 1000: sample requests per beat, range 2..1023.
REQ-004 Parameter TIMEOUT, default 64: maximum clk cycles to wait for voice responses, range 4..255.
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-low; reset==0 at a clk edge resets all state.
REQ-007 new_frame  in  1  raw codec frame level; rising edge detected internally.
REQ-008 play  in  1  1 = mix voices; 0 = output silence.
REQ-009 voice_en  in  NUM_VOICES  per-voice enable; a disabled voice contributes 0 and is not waited for.
REQ-010 voice_sample  in  NUM_VOICES*SAMPLE_W  packed; voice i occupies [i*SAMPLE_W +: SAMPLE_W].
REQ-011 voice_ready  in  NUM_VOICES  per-voice one-cycle pulse: voice_sample slice valid this cycle.
REQ-012 mix_shift  in  2  attenuation; the mixed sum is arithmetically shifted right by this amount.
REQ-013 generate_next_sample  out  1  one-cycle request to all voices.
REQ-014 new_sample_generated  out  1  one-cycle pulse in the cycle sample_out updates.
REQ-015 sample_out  out  SAMPLE_W  codec sample; changes only on frame edges.
REQ-016 beat  out  1  one-cycle pulse once every BEAT_COUNT requests.
REQ-017 overrun  out  1  sticky: a frame edge arrived before the mix was complete.
REQ-018 voice_timeout  out  1  sticky: an enabled voice missed the TIMEOUT deadline.

Function
REQ-019 FSM states and transitions:
- IDLE -> COLLECT on a frame edge.
- COLLECT -> MIX when every enabled voice has a latched ready, or when TIMEOUT cycles have elapsed since the request.
- MIX -> HOLD after NUM_VOICES cycles.
- HOLD -> COLLECT on a frame edge.
REQ-020 Frame edge definition: new_frame==1 and its value registered on the previous cycle == 0.
REQ-021 Frame edge in IDLE or HOLD: generate_next_sample pulses in the same cycle, and the voice ready/latch bits and the timeout counter clear.
REQ-022 Frame edge in HOLD, same cycle: the pending mix loads into sample_out and new_sample_generated pulses.
REQ-023 In COLLECT, a voice_ready[i] pulse latches slice i into a per-voice holding register and sets ready bit i.
- A later pulse for the same voice in the same frame overwrites the holding register.
REQ-024 voice_ready pulses outside COLLECT are ignored.
REQ-025 A ready pulse and timeout expiry in the same cycle: the ready is accepted before the transition.
REQ-026 Timeout: any enabled voice without a ready bit contributes its previous holding-register value, and voice_timeout sets.
REQ-027 MIX is sequential, one voice per cycle, into an accumulator SAMPLE_W+3 bits wide; the accumulator cannot overflow.
REQ-028 After MIX the sum is arithmetically shifted right by mix_shift, then saturated to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
REQ-029 mix_shift and voice_en are sampled once, at the request cycle, and held for that frame.
REQ-030 play==0 at the request cycle: the pending mix is forced to 0.
- Requests, beats and voice latching still occur.
REQ-031 Frame edge in COLLECT or MIX (overrun):
- sample_out holds its value; no request and no new_sample_generated pulse.
- overrun sets; the current mix continues to HOLD.
REQ-032 Beat counter increments on each generate_next_sample pulse.
- Reaching BEAT_COUNT-1: beat pulses with that request and the counter wraps to 0.
REQ-033 No output is combinationally dependent on any input except through the registered frame-edge detect.

Reset
REQ-034 On reset==0 at a clk edge, all of the following clear to 0: sample_out, generate_next_sample, new_sample_generated, beat, overrun, voice_timeout, the beat counter, the holding registers and the edge-detect register; FSM -> IDLE.
REQ-035 Reset mid-frame abandons the mix in progress.
- The first frame edge after release issues a request; the sample_out update follows at the next edge.

Verification (NUM_VOICES=3, SAMPLE_W=18, BEAT_COUNT=4, TIMEOUT=16)
REQ-036 Basic mix: voices return 1000, 2000, -500; play=1, shift=0 -> next frame edge: sample_out=2500 and a new_sample_generated pulse.
REQ-037 Saturation: voices return 131071, 131071, 0 -> sample_out=131071; voices return -131072 x3 with shift=1 -> sample_out=-131072.
REQ-038 Timeout: voice 2 is silent and previously held 300; voices 0 and 1 return 10 and 20 -> sample_out=330, voice_timeout=1 (sticky) after cycle 16.
REQ-039 Overrun: frame edges 5 cycles apart with TIMEOUT=16 -> overrun=1, sample_out unchanged at that edge, no generate_next_sample pulse.
REQ-040 Beat and mute: 8 requests -> beat pulses on requests 4 and 8; play=0 -> sample_out=0 at the following edge while requests continue.
